// File: rtl/mem_stage_pkg.sv
// Shared opcode, funct3 and FSM encodings for the memory stage and its neighbours.
package mem_stage_pkg;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_SAVE = 7'b0100011;
    localparam logic [6:0] OP_ALOP = 7'b0110011;
    localparam logic [6:0] OP_ALOPI = 7'b0010011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] ZeroWord = 32'h0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } mem_state_e;
endpackage

// File: rtl/mem_stage_load_extend.sv
// Turns the little-endian load accumulator into the architectural register value.
module load_extend
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] acc_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] ext_o
);
    always_comb begin
        unique case (funct3_i)
            F3_LB:   ext_o = {{(XLEN-8){acc_i[7]}}, acc_i[7:0]};
            F3_LH:   ext_o = {{(XLEN-16){acc_i[15]}}, acc_i[15:0]};
            F3_LBU:  ext_o = {{(XLEN-8){1'b0}}, acc_i[7:0]};
            F3_LHU:  ext_o = {{(XLEN-16){1'b0}}, acc_i[15:0]};
            default: ext_o = acc_i;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial LOAD/SAVE on an 8-bit controller port, pass-through otherwise.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [6:0]        ins_type,
    input  logic [2:0]        ins_details,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [XLEN-1:0]   rd_val,
    input  logic              forward_in,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_val,
    output logic              mc_req,
    output logic              mc_we,
    output logic [XLEN-1:0]   mc_addr,
    output logic [7:0]        mc_wdata,
    input  logic              mc_ack,
    input  logic [7:0]        mc_rdata,
    output logic [REG_AW-1:0] wb_rd_addr,
    output logic [XLEN-1:0]   wb_rd_val,
    output logic              forward,
    output logic              stall_req
);
    mem_state_e        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic              is_load, is_save, legal;
    logic [1:0]        last_idx;
    logic [XLEN-1:0]   ext_val;

    assign is_load = (ins_type == OP_LOAD);
    assign is_save = (ins_type == OP_SAVE);

    always_comb begin
        legal = 1'b0;
        if (is_load)
            legal = (ins_details inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        else if (is_save)
            legal = !ins_details[2] && (ins_details[1:0] != 2'b11);
    end

    always_comb begin
        unique case (ins_details[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    load_extend #(.XLEN(XLEN)) u_ext (
        .acc_i   (acc_q),
        .funct3_i(ins_details),
        .ext_o   (ext_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_IDLE: if (legal) begin
                state_d = S_ACCESS;
                cnt_d   = 2'd0;
                acc_d   = ZeroWord[XLEN-1:0];
            end
            S_ACCESS: if (mc_ack) begin
                if (is_load) acc_d[{cnt_q, 3'b000} +: 8] = mc_rdata;
                if (cnt_q == last_idx) state_d = S_DONE;
                else                   cnt_d   = cnt_q + 2'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // rdy_in low freezes everything, including any ack the controller sent meanwhile
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            acc_q   <= ZeroWord[XLEN-1:0];
        end else if (rdy_in) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        mc_req     = 1'b0;
        mc_we      = 1'b0;
        mc_addr    = '0;
        mc_wdata   = 8'h00;
        wb_rd_addr = '0;
        wb_rd_val  = '0;
        forward    = 1'b0;
        stall_req  = 1'b0;
        if (!rst_in) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_load || is_save) begin
                        stall_req = legal;
                    end else begin
                        wb_rd_addr = rd_addr;
                        wb_rd_val  = rd_val;
                        forward    = forward_in;
                    end
                end
                S_ACCESS: begin
                    mc_req    = 1'b1;
                    mc_we     = is_save;
                    mc_addr   = mem_addr + XLEN'(cnt_q);
                    mc_wdata  = mem_val[{cnt_q, 3'b000} +: 8];
                    stall_req = 1'b1;
                end
                S_DONE: if (is_load) begin
                    wb_rd_addr = rd_addr;
                    wb_rd_val  = ext_val;
                    forward    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table for IDLE decode, randomized transactions against a byte-memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in;
    logic [6:0]  ins_type;
    logic [2:0]  ins_details;
    logic [4:0]  rd_addr;
    logic [31:0] rd_val, mem_addr, mem_val;
    logic        forward_in;
    logic        mc_req, mc_we, mc_ack;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata, mc_rdata;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_val;
    logic        forward, stall_req;

    int total = 0;
    int bad   = 0;
    bit spur  = 0;

    typedef struct { logic [31:0] addr; logic we; logic [7:0] wdata; } xfer_t;
    xfer_t xlog[$];
    logic [7:0] mem [logic [31:0]];

    mem_stage dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .ins_type(ins_type), .ins_details(ins_details), .rd_addr(rd_addr),
        .rd_val(rd_val), .forward_in(forward_in), .mem_addr(mem_addr), .mem_val(mem_val),
        .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_ack(mc_ack), .mc_rdata(mc_rdata),
        .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val), .forward(forward), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
    endfunction

    // Memory controller: random ack latency; a byte only counts if the stage was enabled.
    bit          have_req = 0;
    logic [31:0] h_addr;
    logic        h_we;
    logic [7:0]  h_wd;
    always @(negedge clk) begin
        mc_ack   = spur || (mc_req && ($urandom_range(0, 2) == 0));
        mc_rdata = mc_req ? rd_byte(mc_addr) : 8'h00;
        if (!mc_req) have_req = 0;
        else if (have_req) begin
            chk("req_addr_stable", mc_addr, h_addr);
            chk("req_we_stable", {31'b0, mc_we}, {31'b0, h_we});
            chk("req_wdata_stable", {24'b0, mc_wdata}, {24'b0, h_wd});
        end else begin
            have_req = 1; h_addr = mc_addr; h_we = mc_we; h_wd = mc_wdata;
        end
        if (mc_ack && mc_req && rdy_in) begin
            xlog.push_back('{mc_addr, mc_we, mc_wdata});
            if (mc_we) mem[mc_addr] = mc_wdata;
            have_req = 0;
        end
    end

    task automatic nop();
        ins_type = OP_ALOPI; ins_details = 3'b000; rd_addr = 5'd0;
        rd_val = 32'h0; forward_in = 1'b0; mem_addr = 32'h0; mem_val = 32'h0;
    endtask

    task automatic run_mem(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] val, input bit freeze);
        int n;
        longint v;
        logic [31:0] exp_v;
        bit done;
        bit ld;
        ld = (op == OP_LOAD);
        n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        v  = 0;
        for (int i = 0; i < n; i++) v += longint'(rd_byte(addr + 32'(i))) << (8 * i);
        if (f3 == F3_LB && v >= 128)   v -= 256;
        if (f3 == F3_LH && v >= 32768) v -= 65536;
        exp_v = 32'(v);
        xlog.delete();
        ins_type = op; ins_details = f3; rd_addr = rd; mem_addr = addr; mem_val = val;
        rd_val = 32'hDEAD_BEEF; forward_in = 1'b1;
        #1;
        chk("idle_stall", {31'b0, stall_req}, 32'd1);
        chk("idle_no_req", {31'b0, mc_req}, 32'd0);
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            if (!stall_req) done = 1;
            else begin
                chk("access_wb_zero", {26'b0, forward, wb_rd_addr}, 32'd0);
                if (freeze && c == 0) begin
                    rdy_in = 1'b0; spur = 1;
                    for (int k = 0; k < 3; k++) begin
                        @(posedge clk); #1;
                        spur = 0;
                        chk("freeze_stall", {31'b0, stall_req}, 32'd1);
                        chk("freeze_req", {31'b0, mc_req}, 32'd1);
                        chk("freeze_addr", mc_addr, addr);
                    end
                    rdy_in = 1'b1;
                end
            end
        end
        chk("done_reached", {31'b0, done}, 32'd1);
        chk("done_no_req", {31'b0, mc_req}, 32'd0);
        chk("done_wb_addr", {27'b0, wb_rd_addr}, ld ? {27'b0, rd} : 32'd0);
        chk("done_forward", {31'b0, forward}, {31'b0, ld});
        if (ld) chk("done_load_val", wb_rd_val, exp_v);
        chk("byte_count", xlog.size(), n);
        for (int i = 0; i < n && i < xlog.size(); i++) begin
            chk("byte_addr", xlog[i].addr, addr + 32'(i));
            chk("byte_we", {31'b0, xlog[i].we}, {31'b0, !ld});
            if (!ld) chk("byte_wdata", {24'b0, xlog[i].wdata}, {24'b0, val[8*i +: 8]});
        end
        @(posedge clk); #1;
        nop();
        #1;
        chk("back_idle", {31'b0, stall_req}, 32'd0);
    endtask

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic [4:0] rd; logic [31:0] val; logic fin;
        logic [4:0] e_rd; logic [31:0] e_val; logic e_fwd;
    } vec_t;
    vec_t vt[8];

    initial begin
        vt[0] = '{OP_ALOP,  3'b000, 5'd5,  32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234, 1'b1};
        vt[1] = '{OP_ALOPI, 3'b111, 5'd31, 32'hFFFF_0001, 1'b0, 5'd31, 32'hFFFF_0001, 1'b0};
        vt[2] = '{7'b0110111, 3'b010, 5'd1, 32'h8000_0000, 1'b1, 5'd1, 32'h8000_0000, 1'b1};
        vt[3] = '{OP_LOAD,  3'b011, 5'd9,  32'h1111_1111, 1'b1, 5'd0,  32'h0, 1'b0};
        vt[4] = '{OP_LOAD,  3'b110, 5'd9,  32'h1111_1111, 1'b1, 5'd0,  32'h0, 1'b0};
        vt[5] = '{OP_LOAD,  3'b111, 5'd9,  32'h1111_1111, 1'b1, 5'd0,  32'h0, 1'b0};
        vt[6] = '{OP_SAVE,  3'b100, 5'd3,  32'h2222_2222, 1'b1, 5'd0,  32'h0, 1'b0};
        vt[7] = '{OP_SAVE,  3'b011, 5'd3,  32'h2222_2222, 1'b1, 5'd0,  32'h0, 1'b0};

        mc_ack = 0; mc_rdata = 0;
        rst_in = 1'b1; rdy_in = 1'b1;
        ins_type = OP_LOAD; ins_details = F3_LW; rd_addr = 5'd3; rd_val = 32'h55;
        forward_in = 1'b1; mem_addr = 32'h40; mem_val = 32'h0;
        #2;
        chk("rst_outputs", {mc_req, mc_we, stall_req, forward, wb_rd_addr}, 32'd0);
        chk("rst_wb_val", wb_rd_val, 32'd0);
        nop();
        @(posedge clk); #1;
        rst_in = 1'b0;
        #1;

        foreach (vt[i]) begin
            ins_type = vt[i].op; ins_details = vt[i].f3; rd_addr = vt[i].rd;
            rd_val = vt[i].val; forward_in = vt[i].fin; mem_addr = 32'h100; mem_val = 32'h0;
            #1;
            chk("vec_wb_addr", {27'b0, wb_rd_addr}, {27'b0, vt[i].e_rd});
            chk("vec_wb_val", wb_rd_val, vt[i].e_val);
            chk("vec_fwd", {31'b0, forward}, {31'b0, vt[i].e_fwd});
            chk("vec_stall", {31'b0, stall_req}, 32'd0);
            @(posedge clk); #1;
            chk("vec_no_req", {31'b0, mc_req}, 32'd0);
        end
        nop();

        mem[32'h100] = 8'h80;
        run_mem(OP_LOAD, F3_LB,  5'd4, 32'h100, 32'h0, 0);
        run_mem(OP_LOAD, F3_LBU, 5'd4, 32'h100, 32'h0, 0);
        mem[32'h200] = 8'h78; mem[32'h201] = 8'h56; mem[32'h202] = 8'h34; mem[32'h203] = 8'h12;
        run_mem(OP_LOAD, F3_LW,  5'd6, 32'h200, 32'h0, 0);
        run_mem(OP_SAVE, F3_SH,  5'd6, 32'h301, 32'hAABB_CCDD, 0);
        run_mem(OP_LOAD, F3_LW,  5'd7, 32'h200, 32'h0, 1);
        run_mem(OP_SAVE, F3_SW,  5'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0);
        run_mem(OP_LOAD, F3_LH,  5'd0, 32'hFFFF_FFFF, 32'h0, 0);

        // Reset asserted in the middle of a word access
        xlog.delete();
        ins_type = OP_LOAD; ins_details = F3_LW; rd_addr = 5'd8; mem_addr = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'b0, mc_req}, 32'd1);
        rst_in = 1'b1;
        #1;
        chk("rst_mid_req", {31'b0, mc_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall_req}, 32'd0);
        nop();
        @(posedge clk); #1;
        rst_in = 1'b0;
        #1;
        chk("post_rst_idle", {31'b0, stall_req}, 32'd0);

        for (int t = 0; t < 40; t++) begin
            logic [6:0]  op;
            logic [2:0]  f3;
            logic [31:0] a;
            int          s;
            op = $urandom_range(0, 1) ? OP_LOAD : OP_SAVE;
            s  = $urandom_range(0, 4);
            if (op == OP_LOAD) f3 = (s == 0) ? F3_LB : (s == 1) ? F3_LH : (s == 2) ? F3_LW : (s == 3) ? F3_LBU : F3_LHU;
            else               f3 = (s < 2) ? F3_SB : (s < 4) ? F3_SH : F3_SW;
            a = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : (32'h1000 + 32'($urandom_range(0, 63)));
            run_mem(op, f3, 5'($urandom), a, $urandom, ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
